// File: rtl/ehgu_debounce.sv
// Synchronizes and debounces an asynchronous single-bit input; a new level must hold
// for STABLE_CYCLES synchronized samples before dout follows. Rejected pulses are counted.
module ehgu_debounce #(
  parameter int   SYNC_STAGES      = 2,
  parameter int   STABLE_CYCLES    = 4,
  parameter int   GLITCH_CNT_WIDTH = 8,
  parameter logic RESET_VALUE      = 1'b0
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        din_async,
  input  logic                        glitch_clr,
  output logic                        dout,
  output logic                        busy,
  output logic                        glitch,
  output logic [GLITCH_CNT_WIDTH-1:0] glitch_cnt
);

  localparam int CNT_WIDTH = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {STABLE_LO, CHK_HI, STABLE_HI, CHK_LO} state_t;

  localparam state_t                    RST_STATE  = RESET_VALUE ? STABLE_HI : STABLE_LO;
  localparam logic [CNT_WIDTH-1:0]        CNT_TARGET = CNT_WIDTH'(STABLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0]        CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [GLITCH_CNT_WIDTH-1:0] GCNT_ONE   = GLITCH_CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0]      sync_q, sync_d;
  state_t                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                        dout_q, dout_d;
  logic                        busy_q, busy_d;
  logic                        glitch_q, glitch_d;
  logic [GLITCH_CNT_WIDTH-1:0] glitch_cnt_q, glitch_cnt_d;
  logic                        din_s;

  // Synchronizer: only the last stage is ever observed by the FSM.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], din_async};
  assign din_s  = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    glitch_d = 1'b0;
    cnt_inc  = cnt_q + CNT_ONE;
    case (state_q)
      STABLE_LO: begin
        if (din_s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = STABLE_HI;
            dout_d  = 1'b1;
          end else begin
            state_d = CHK_HI;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_HI: begin
        if (din_s) begin
          if (cnt_inc == CNT_TARGET) begin
            state_d = STABLE_HI;
            dout_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d  = STABLE_LO;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end
      end
      STABLE_HI: begin
        if (!din_s) begin
          if (STABLE_CYCLES == 1) begin
            state_d = STABLE_LO;
            dout_d  = 1'b0;
          end else begin
            state_d = CHK_LO;
            cnt_d   = CNT_ONE;
          end
        end
      end
      CHK_LO: begin
        if (!din_s) begin
          if (cnt_inc == CNT_TARGET) begin
            state_d = STABLE_LO;
            dout_d  = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          state_d  = STABLE_HI;
          cnt_d    = '0;
          glitch_d = 1'b1;
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
        dout_d  = RESET_VALUE;
      end
    endcase
    busy_d = (state_d == CHK_HI) || (state_d == CHK_LO);
  end

  // A clear coinciding with a new rejection still records that rejection.
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (glitch_d) begin
      if (glitch_clr)
        glitch_cnt_d = GCNT_ONE;
      else if (glitch_cnt_q != '1)
        glitch_cnt_d = glitch_cnt_q + GCNT_ONE;
    end else if (glitch_clr) begin
      glitch_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q       <= {SYNC_STAGES{RESET_VALUE}};
      state_q      <= RST_STATE;
      cnt_q        <= '0;
      dout_q       <= RESET_VALUE;
      busy_q       <= 1'b0;
      glitch_q     <= 1'b0;
      glitch_cnt_q <= '0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
      glitch_q     <= glitch_d;
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign dout       = dout_q;
  assign busy       = busy_q;
  assign glitch     = glitch_q;
  assign glitch_cnt = glitch_cnt_q;

endmodule
